pe_operand_skew_feeder: RTL

//   West-edge operand feeder for the torus systolic array of PE MAC cells.

---
 rtl/pe_operand_skew_feeder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pe_operand_skew_feeder.sv
`timescale 1ns/1ps
// West-edge operand feeder for the torus systolic array.
// Row vectors of A operands are queued in a small FIFO, issued one per cycle,
// and skewed so lane k reaches the array edge k cycles after lane 0. Each
// tile is followed by LANES-1 bubble cycles so its last operands drain.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | nothing issued; waits for the FIFO to hold a vector
//   S_STREAM | pops and issues one vector per cycle, bubble when starved
//   S_FLUSH  | issues bubbles for LANES-1 cycles after the tile's last vector
module pe_operand_skew_feeder #(
    parameter int OPERAND_WIDTH = 8,
    parameter int LANES         = 4,
    parameter int DEPTH         = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*OPERAND_WIDTH-1:0]   in_data,
    input  logic                             in_last,
    input  logic                             stall_i,
    output logic [LANES*OPERAND_WIDTH-1:0]   a_o,
    output logic [LANES-1:0]                 a_valid_o,
    output logic                             done_o
);

    localparam int VW     = LANES * OPERAND_WIDTH;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FCNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [FCNT_W-1:0]   w_fcnt_nxt;

    logic [VW-1:0]       r_mem_data [DEPTH];
    logic                r_mem_last [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [VW-1:0]       w_head_data;
    logic                w_head_last;

    logic [VW-1:0]       w_iss_data;
    logic                w_iss_valid;
    logic                w_iss_last;
    logic [LANES-1:0]    r_last_pipe;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    // Ready only looks at registered state so the upstream handshake never
    // depends on this cycle's pop.
    assign in_ready    = !w_full && (r_state != S_FLUSH);
    assign w_push      = in_valid && in_ready;
    assign w_head_data = r_mem_data[r_rd_ptr];
    assign w_head_last = r_mem_last[r_rd_ptr];

    // FIFO storage: write side runs even while the array is stalled.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_last[r_wr_ptr] <= in_last;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register; stall is folded into the next-state logic.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Next state, pop and issue; a stalled cycle holds everything.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_pop       = 1'b0;
        w_iss_data  = '0;
        w_iss_valid = 1'b0;
        w_iss_last  = 1'b0;
        if (!stall_i) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) w_state_nxt = S_STREAM;
                end
                S_STREAM: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_iss_data  = w_head_data;
                        w_iss_valid = 1'b1;
                        if (w_head_last) begin
                            w_iss_last = 1'b1;
                            if (LANES == 1) begin
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_state_nxt = S_FLUSH;
                                w_fcnt_nxt  = FCNT_W'(LANES - 1);
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    w_fcnt_nxt = r_fcnt - FCNT_W'(1);
                    if (r_fcnt == FCNT_W'(1)) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Per-lane skew lines: lane k has k+1 stages, all frozen by stall.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [OPERAND_WIDTH-1:0] r_dly_data [k+1];
        logic                     r_dly_vld  [k+1];

        // Shift this lane's operand and valid toward the array edge.
        always_ff @(posedge clk_i or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 0; s <= k; s++) begin
                    r_dly_data[s] <= '0;
                    r_dly_vld[s]  <= 1'b0;
                end
            end else if (!stall_i) begin
                r_dly_data[0] <= w_iss_data[k*OPERAND_WIDTH +: OPERAND_WIDTH];
                r_dly_vld[0]  <= w_iss_valid;
                for (int s = 1; s <= k; s++) begin
                    r_dly_data[s] <= r_dly_data[s-1];
                    r_dly_vld[s]  <= r_dly_vld[s-1];
                end
            end
        end

        assign a_o[k*OPERAND_WIDTH +: OPERAND_WIDTH] = r_dly_data[k];
        assign a_valid_o[k]                          = r_dly_vld[k];
    end

    // Last-vector marker travels alongside the deepest lane to time done_o.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_last_pipe <= '0;
        end else if (!stall_i) begin
            r_last_pipe[0] <= w_iss_last;
            for (int s = 1; s < LANES; s++) begin
                r_last_pipe[s] <= r_last_pipe[s-1];
            end
        end
    end

    assign done_o = r_last_pipe[LANES-1];

endmodule
